pifo_calendar_ctrl: RTL and testbench

PIFO_CALENDAR_CTRL -- requirements
Module: pifo_calendar_ctrl

---
 rtl/pifo_calendar_ctrl.sv | 109 ++++++++++
 tb/tb_pifo_calendar_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pifo_calendar_ctrl.sv
// Controller for a chain of PIFO calendar atoms: enqueue/dequeue handshakes,
// round (overflow bit) tracking against the last dequeued rank, and flushing.
module pifo_calendar_ctrl #(
    parameter int DEPTH                   = 16,
    parameter int ELEMENT_WIDTH           = 32,
    parameter int ELEMENT_RANK_WIDTH      = 18,
    parameter int PIFO_INFO_ADDRESS_WIDTH = 12,
    localparam int OCC_W                  = $clog2(DEPTH + 1)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               s_enq_valid,
    output logic                               s_enq_ready,
    input  logic [ELEMENT_RANK_WIDTH-1:0]      s_enq_rank,
    input  logic [PIFO_INFO_ADDRESS_WIDTH-1:0] s_enq_address,
    output logic                               m_deq_valid,
    input  logic                               m_deq_ready,
    output logic [ELEMENT_WIDTH-1:0]           m_deq_data,
    input  logic                               in_flush,
    output logic [ELEMENT_WIDTH-1:0]           out_pifo_input,
    output logic                               out_ctl_insert,
    output logic                               out_ctl_pop,
    output logic                               out_global_overflow_bit,
    input  logic [ELEMENT_WIDTH-1:0]           in_head_element,
    output logic [OCC_W-1:0]                   out_occupancy,
    output logic                               out_full,
    output logic                               out_empty,
    output logic                               out_busy
);
    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

    state_t                        state, state_next;
    logic                          held_valid;
    logic                          global_bit;
    logic [ELEMENT_RANK_WIDTH-1:0] last_deq_rank;
    logic [OCC_W-1:0]              occupancy;
    logic                          pop_ok, flush_pop, insert, pop, enq_ovf;
    logic [ELEMENT_RANK_WIDTH-1:0] head_rank;
    logic                          head_ovf;

    assign head_rank = in_head_element[PIFO_INFO_ADDRESS_WIDTH +: ELEMENT_RANK_WIDTH];
    assign head_ovf  = in_head_element[ELEMENT_WIDTH-2];

    assign out_occupancy           = occupancy;
    assign out_empty               = (occupancy == '0);
    assign out_full                = (occupancy == OCC_W'(DEPTH));
    assign out_busy                = (state == FLUSH);
    assign out_global_overflow_bit = global_bit;
    assign m_deq_valid             = held_valid & (state == RUN);

    // A rank behind the last dequeued one has wrapped and belongs to the next round.
    assign enq_ovf        = (s_enq_rank >= last_deq_rank) ? global_bit : ~global_bit;
    assign out_pifo_input = {1'b1, enq_ovf, s_enq_rank, s_enq_address};

    always_comb begin
        state_next  = state;
        pop_ok      = 1'b0;
        flush_pop   = 1'b0;
        s_enq_ready = 1'b0;
        insert      = 1'b0;
        case (state)
            RUN: begin
                pop_ok      = ~out_empty & (~held_valid | m_deq_ready);
                s_enq_ready = ~out_full | pop_ok;
                insert      = s_enq_valid & s_enq_ready;
                if (in_flush) state_next = FLUSH;
            end
            FLUSH: begin
                flush_pop = ~out_empty;
                if (out_empty) state_next = RUN;
            end
            default: state_next = RUN;
        endcase
        pop            = pop_ok | flush_pop;
        out_ctl_insert = insert & ~rst;
        out_ctl_pop    = pop & ~rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RUN;
            occupancy     <= '0;
            held_valid    <= 1'b0;
            m_deq_data    <= '0;
            global_bit    <= 1'b0;
            last_deq_rank <= '0;
        end else begin
            state <= state_next;
            case ({insert, pop})
                2'b10:   occupancy <= occupancy + OCC_W'(1);
                2'b01:   occupancy <= occupancy - OCC_W'(1);
                default: ;
            endcase
            if (pop_ok) begin
                m_deq_data    <= in_head_element;
                held_valid    <= 1'b1;
                last_deq_rank <= head_rank;
                if (head_ovf != global_bit) global_bit <= head_ovf;
            end else if (state == FLUSH || m_deq_ready) begin
                held_valid <= 1'b0;
            end
            // Chain is empty on exit, so the round numbering restarts from zero.
            if (state == FLUSH && out_empty) begin
                global_bit    <= 1'b0;
                last_deq_rank <= '0;
            end
        end
    end
endmodule

// File: tb/tb_pifo_calendar_ctrl.sv
// Bench for pifo_calendar_ctrl: behavioural atom chain, reference model with
// scoreboard, directed scenarios and a randomized phase.
module tb_pifo_calendar_ctrl;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst, s_enq_valid, s_enq_ready, m_deq_valid, m_deq_ready, in_flush;
    logic [17:0] s_enq_rank;
    logic [11:0] s_enq_address;
    logic [31:0] m_deq_data, out_pifo_input, in_head_element;
    logic        out_ctl_insert, out_ctl_pop, out_global_overflow_bit;
    logic [4:0]  out_occupancy;
    logic        out_full, out_empty, out_busy;

    int checks = 0;
    int failures = 0;

    // reference model state
    bit          r_run = 1'b1;
    int          r_cnt = 0;
    logic        r_mv = 1'b0, r_g = 1'b0;
    logic [17:0] r_last = '0;
    logic [31:0] rq[$];
    logic [31:0] exp_q[$];
    logic [31:0] chain[$];
    logic [11:0] deq_log[$];

    pifo_calendar_ctrl #(.DEPTH(DEPTH), .ELEMENT_WIDTH(32), .ELEMENT_RANK_WIDTH(18),
                         .PIFO_INFO_ADDRESS_WIDTH(12)) dut (
        .clk(clk), .rst(rst),
        .s_enq_valid(s_enq_valid), .s_enq_ready(s_enq_ready),
        .s_enq_rank(s_enq_rank), .s_enq_address(s_enq_address),
        .m_deq_valid(m_deq_valid), .m_deq_ready(m_deq_ready), .m_deq_data(m_deq_data),
        .in_flush(in_flush), .out_pifo_input(out_pifo_input),
        .out_ctl_insert(out_ctl_insert), .out_ctl_pop(out_ctl_pop),
        .out_global_overflow_bit(out_global_overflow_bit),
        .in_head_element(in_head_element), .out_occupancy(out_occupancy),
        .out_full(out_full), .out_empty(out_empty), .out_busy(out_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Ordering key: current-round elements first, then by rank.
    function automatic logic [18:0] key(input logic [31:0] e, input logic g);
        return {e[30] ^ g, e[29:12]};
    endfunction

    // Behavioural atom chain reacting to the DUT's strobes.
    initial begin : chain_model
        logic [31:0] nh;
        int p;
        in_head_element = '0;
        forever begin
            @(negedge clk);
            if (rst) chain.delete();
            else begin
                if (out_ctl_pop && chain.size() > 0) void'(chain.pop_front());
                if (out_ctl_insert) begin
                    p = chain.size();
                    for (int i = 0; i < chain.size(); i++)
                        if (key(chain[i], out_global_overflow_bit) >
                            key(out_pifo_input, out_global_overflow_bit)) begin
                            p = i;
                            break;
                        end
                    chain.insert(p, out_pifo_input);
                end
            end
            nh = (chain.size() > 0) ? chain[0] : 32'd0;
            @(posedge clk);
            in_head_element <= nh;
        end
    end

    // Monitor: compares whatever the DUT presents against the scoreboard.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!rst && m_deq_valid) begin
                if (exp_q.size() == 0) chk("deq_unexpected", {31'd0, m_deq_valid}, 32'd0);
                else begin
                    chk("deq_data", m_deq_data, exp_q[0]);
                    if (m_deq_ready) begin
                        deq_log.push_back(exp_q[0][11:0]);
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    // Reference model: predicts handshakes and the element order from the rules.
    initial begin : ref_model
        logic pop_ok, rdy, ins, fpop, ovf;
        logic [31:0] e, h;
        int p;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                chk("rst_insert_gated", {31'd0, out_ctl_insert}, 32'd0);
                chk("rst_pop_gated", {31'd0, out_ctl_pop}, 32'd0);
                r_run = 1'b1; r_cnt = 0; r_mv = 1'b0; r_g = 1'b0; r_last = '0;
                rq.delete(); exp_q.delete();
            end else begin
                if (!r_run) exp_q.delete();
                pop_ok = r_run && r_cnt > 0 && (!r_mv || m_deq_ready);
                rdy    = r_run && (r_cnt < DEPTH || pop_ok);
                ins    = s_enq_valid && rdy;
                fpop   = !r_run && r_cnt > 0;
                chk("enq_ready", {31'd0, s_enq_ready}, {31'd0, rdy});
                chk("ctl_insert", {31'd0, out_ctl_insert}, {31'd0, ins});
                chk("ctl_pop", {31'd0, out_ctl_pop}, {31'd0, pop_ok || fpop});
                chk("occupancy", {27'd0, out_occupancy}, r_cnt);
                chk("full", {31'd0, out_full}, {31'd0, r_cnt == DEPTH});
                chk("empty", {31'd0, out_empty}, {31'd0, r_cnt == 0});
                chk("busy", {31'd0, out_busy}, {31'd0, !r_run});
                chk("deq_valid", {31'd0, m_deq_valid}, {31'd0, r_run && r_mv});
                chk("global_bit", {31'd0, out_global_overflow_bit}, {31'd0, r_g});
                e = '0;
                if (ins) begin
                    ovf = (s_enq_rank >= r_last) ? r_g : !r_g;
                    e = {1'b1, ovf, s_enq_rank, s_enq_address};
                    chk("pifo_input", out_pifo_input, e);
                end
                h = '0;
                if ((pop_ok || fpop) && rq.size() > 0) h = rq.pop_front();
                if (ins) begin
                    p = rq.size();
                    for (int i = 0; i < rq.size(); i++)
                        if (key(rq[i], r_g) > key(e, r_g)) begin p = i; break; end
                    rq.insert(p, e);
                end
                if (pop_ok) begin
                    exp_q.push_back(h);
                    r_last = h[29:12];
                    r_g    = h[30];
                end
                if (pop_ok) r_mv = 1'b1;
                else if (!r_run || m_deq_ready) r_mv = 1'b0;
                if (r_run && in_flush) r_run = 1'b0;
                else if (!r_run && r_cnt == 0) begin
                    r_run = 1'b1; r_g = 1'b0; r_last = '0;
                end
                r_cnt = r_cnt + (ins ? 1 : 0) - ((pop_ok || fpop) ? 1 : 0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; s_enq_valid = 1'b0; in_flush = 1'b0; m_deq_ready = 1'b0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic enq(input logic [17:0] r, input logic [11:0] a);
        s_enq_valid = 1'b1; s_enq_rank = r; s_enq_address = a;
        step();
        s_enq_valid = 1'b0;
    endtask

    initial begin : stimulus
        logic [11:0] exp_order[$];
        logic [31:0] held;
        int busy_cnt, pop_cnt, tmp;

        rst = 1'b1; s_enq_valid = 1'b0; s_enq_rank = '0; s_enq_address = '0;
        m_deq_ready = 1'b0; in_flush = 1'b0;
        repeat (3) step();
        chk("reset_occupancy", {27'd0, out_occupancy}, 32'd0);
        chk("reset_empty", {31'd0, out_empty}, 32'd1);
        chk("reset_full", {31'd0, out_full}, 32'd0);
        chk("reset_deq_valid", {31'd0, m_deq_valid}, 32'd0);
        chk("reset_deq_data", m_deq_data, 32'd0);
        chk("reset_busy", {31'd0, out_busy}, 32'd0);
        chk("reset_global", {31'd0, out_global_overflow_bit}, 32'd0);
        rst = 1'b0;

        // ordering: a dummy element parks in the output register so 30,10,20 queue up
        deq_log.delete();
        enq(18'd0, 12'd0); enq(18'd30, 12'd1); enq(18'd10, 12'd2); enq(18'd20, 12'd3);
        chk("order_occupancy", {27'd0, out_occupancy}, 32'd3);
        m_deq_ready = 1'b1;
        repeat (6) step();
        exp_order = '{12'd0, 12'd2, 12'd3, 12'd1};
        chk("order_count", deq_log.size(), 32'd4);
        for (int i = 0; i < 4 && i < deq_log.size(); i++)
            chk("order_addr", {20'd0, deq_log[i]}, {20'd0, exp_order[i]});

        // full chain: insert only alongside a pop
        do_reset();
        for (int i = 0; i < DEPTH + 1; i++) enq(18'(100 + i), 12'(i));
        chk("full_occupancy", {27'd0, out_occupancy}, 32'd16);
        chk("full_flag", {31'd0, out_full}, 32'd1);
        chk("full_not_ready", {31'd0, s_enq_ready}, 32'd0);
        chk("full_deq_valid", {31'd0, m_deq_valid}, 32'd1);
        m_deq_ready = 1'b1; s_enq_valid = 1'b1; s_enq_rank = 18'd50; s_enq_address = 12'h50;
        #1;
        chk("full_insert", {31'd0, out_ctl_insert}, 32'd1);
        chk("full_pop", {31'd0, out_ctl_pop}, 32'd1);
        step();
        s_enq_valid = 1'b0;
        chk("full_occ_kept", {27'd0, out_occupancy}, 32'd16);
        repeat (20) step();
        chk("full_drained", {31'd0, out_empty}, 32'd1);

        // round wrap
        do_reset();
        deq_log.delete();
        enq(18'd200000, 12'd7);
        step();
        s_enq_valid = 1'b1; s_enq_rank = 18'd5; s_enq_address = 12'd8;
        #1; chk("wrap_ovf_set", {31'd0, out_pifo_input[30]}, 32'd1);
        step();
        s_enq_rank = 18'd250000; s_enq_address = 12'd9;
        #1; chk("wrap_ovf_clear", {31'd0, out_pifo_input[30]}, 32'd0);
        step();
        s_enq_valid = 1'b0; m_deq_ready = 1'b1;
        repeat (6) step();
        exp_order = '{12'd7, 12'd9, 12'd8};
        chk("wrap_count", deq_log.size(), 32'd3);
        for (int i = 0; i < 3 && i < deq_log.size(); i++)
            chk("wrap_addr", {20'd0, deq_log[i]}, {20'd0, exp_order[i]});
        chk("wrap_global", {31'd0, out_global_overflow_bit}, 32'd1);

        // stall: element held with m_deq_ready low
        m_deq_ready = 1'b0;
        enq(18'd1000, 12'h21); enq(18'd1001, 12'h22);
        step();
        held = {1'b1, 1'b1, 18'd1000, 12'h21};
        for (int i = 0; i < 5; i++) begin
            chk("stall_data", m_deq_data, held);
            chk("stall_no_pop", {31'd0, out_ctl_pop}, 32'd0);
            chk("stall_occ", {27'd0, out_occupancy}, 32'd1);
            step();
        end
        m_deq_ready = 1'b1;
        repeat (4) step();

        // flush at occupancy 6
        do_reset();
        for (int i = 0; i < 7; i++) enq(18'(i * 10), 12'(i));
        chk("flush_pre_occ", {27'd0, out_occupancy}, 32'd6);
        in_flush = 1'b1; step(); in_flush = 1'b0;
        busy_cnt = 0; pop_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_busy) begin
                busy_cnt++;
                if (out_ctl_pop) pop_cnt++;
            end
            step();
        end
        chk("flush_busy_cycles", busy_cnt, 32'd7);
        chk("flush_pops", pop_cnt, 32'd6);
        chk("flush_empty", {31'd0, out_empty}, 32'd1);
        chk("flush_global", {31'd0, out_global_overflow_bit}, 32'd0);

        // reset in the middle of a flush
        do_reset();
        for (int i = 0; i < 4; i++) enq(18'(i + 3), 12'(i));
        in_flush = 1'b1; step(); in_flush = 1'b0;
        chk("rstflush_busy", {31'd0, out_busy}, 32'd1);
        rst = 1'b1; step(); rst = 1'b0;
        chk("rstflush_run", {31'd0, out_busy}, 32'd0);
        chk("rstflush_occ", {27'd0, out_occupancy}, 32'd0);
        chk("rstflush_valid", {31'd0, m_deq_valid}, 32'd0);
        chk("rstflush_data", m_deq_data, 32'd0);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            s_enq_valid = ($urandom % 3) != 0;
            tmp = int'(r_last) + int'($urandom_range(0, 4000)) - 1000;
            s_enq_rank = tmp[17:0];
            s_enq_address = 12'($urandom);
            m_deq_ready = ($urandom % 4) != 0;
            in_flush = ($urandom % 60) == 0;
            rst = ($urandom % 500) == 0;
            step();
        end
        rst = 1'b0; s_enq_valid = 1'b0; in_flush = 1'b0; m_deq_ready = 1'b1;
        repeat (40) step();
        chk("final_empty", {31'd0, out_empty}, 32'd1);
        chk("final_scoreboard", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
